// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
// Shared definitions for the rv32 data-memory bridge: FSM state encoding,
// the fixed word byte-enable pattern, the data returned to the core when a
// bus access is abandoned by the watchdog, and an alignment helper.
// ---------------------------------------------------------------------------
package rv32_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } dmem_state_e;

  localparam logic [3:0]  DMEM_BE_WORD      = 4'hF;
  localparam logic [31:0] DMEM_TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Word accesses only: both low address bits must be zero.
  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/rv32_dmem_watchdog.sv
// ---------------------------------------------------------------------------
// rv32_dmem_watchdog
// Counts the cycles a bus access spends outstanding and raises expire once
// TIMEOUT_CYCLES cycles have elapsed. The counter saturates at the limit so
// expire stays asserted until the bridge leaves the outstanding states.
//
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   clear    in   new access launched; restart the count
//   active   in   bridge is in REQ or WAIT
//   expire   out  limit reached while active
// ---------------------------------------------------------------------------
module rv32_dmem_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic active,
  output logic expire
);

  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_RAW > 8) ? CW_RAW : 8;
  // The first outstanding cycle sees a count of zero, so the last allowed
  // cycle is at TIMEOUT_CYCLES-1.
  localparam int LIMIT  = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;

  logic [CW-1:0] cnt_r;

  assign expire = active && (cnt_r >= CW'(LIMIT));

  // Outstanding-cycle counter, restarted on launch and frozen at the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (active && !expire) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/rv32_dmem_bridge.sv
// ---------------------------------------------------------------------------
// rv32_dmem_bridge
// Turns the single-cycle core's zero-latency data access into a
// request/grant/response bus transaction and stalls the core until the
// access has completed. Each access ends in a one-cycle DONE state with
// stall low, in which the core commits and advances its pc.
//
// Optional build macro: DMEM_TIMEOUT_EN -- enables rv32_dmem_watchdog; an
// access outstanding for TIMEOUT_CYCLES cycles is abandoned, reads return
// 32'hDEAD_BEEF and the sticky bus_error flag is set.
//
// Ports:
//   clk, reset_n                 clock / asynchronous active-low reset
//   address, MemRead, MemWrite,  core data access
//   wdata
//   rdata                        load data to the core (held outside DONE)
//   stall                        hold core pc/regfile while 1
//   bus_req/bus_we/bus_addr/     registered bus request
//   bus_wdata/bus_be
//   bus_gnt, bus_rvalid,         bus grant and response
//   bus_rdata
//   misaligned                   one-cycle pulse: misaligned access dropped
//   bus_error                    sticky watchdog error, cleared by reset
// ---------------------------------------------------------------------------
module rv32_dmem_bridge
  import rv32_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] address,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          stall,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic [3:0]    bus_be,
  input  logic          bus_gnt,
  input  logic          bus_rvalid,
  input  logic [DW-1:0] bus_rdata,
  output logic          misaligned,
  output logic          bus_error
);

  dmem_state_e   state_r;
  dmem_state_e   state_nxt_s;

  logic          acc_s;
  logic          launch_s;
  logic          misalign_s;
  logic          capture_s;
  logic          timeout_s;
  logic          tmo_expire_s;

  logic          bus_req_r;
  logic          bus_we_r;
  logic [AW-1:0] bus_addr_r;
  logic [DW-1:0] bus_wdata_r;
  logic [DW-1:0] rdata_r;
  logic          misaligned_r;
  logic          bus_error_r;

  // While reset is held the state is already IDLE; gating the access here
  // keeps stall low immediately even if the core still presents a request.
  assign acc_s = (MemRead | MemWrite) & reset_n;

`ifdef DMEM_TIMEOUT_EN
  logic wd_active_s;

  assign wd_active_s = (state_r == REQ) || (state_r == WAIT);

  rv32_dmem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (launch_s),
    .active (wd_active_s),
    .expire (tmo_expire_s)
  );
`else
  // Watchdog compiled out: never expires. The parameter is still referenced
  // so both builds share one interface.
  assign tmo_expire_s = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, stall and datapath strobes.
  always_comb begin
    state_nxt_s = state_r;
    stall       = 1'b0;
    launch_s    = 1'b0;
    misalign_s  = 1'b0;
    capture_s   = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (acc_s) begin
          stall = 1'b1;
          if (is_word_aligned(address[1:0])) begin
            launch_s    = 1'b1;
            state_nxt_s = REQ;
          end else begin
            misalign_s  = 1'b1;
            state_nxt_s = DONE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_gnt && bus_rvalid) begin
          capture_s   = 1'b1;
          state_nxt_s = DONE;
        end else if (bus_gnt) begin
          state_nxt_s = WAIT;
        end else if (tmo_expire_s) begin
          timeout_s   = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (bus_rvalid) begin
          capture_s   = 1'b1;
          state_nxt_s = DONE;
        end else if (tmo_expire_s) begin
          timeout_s   = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DONE: begin
        // The core still shows the retiring access here; it is not relaunched.
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Bus request: high for exactly the cycles spent in REQ.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_req_r <= 1'b0;
    end else begin
      bus_req_r <= (state_nxt_s == REQ);
    end
  end

  // Request attributes latched at launch and held through REQ and WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_we_r    <= 1'b0;
      bus_addr_r  <= '0;
      bus_wdata_r <= '0;
    end else if (launch_s) begin
      bus_we_r    <= MemWrite;
      bus_addr_r  <= {address[AW-1:2], 2'b00};
      bus_wdata_r <= wdata;
    end else begin
      bus_we_r    <= bus_we_r;
      bus_addr_r  <= bus_addr_r;
      bus_wdata_r <= bus_wdata_r;
    end
  end

  // Load data returned to the core; only changes on the way into DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_r <= '0;
    end else if (misalign_s) begin
      rdata_r <= '0;
    end else if (capture_s && !bus_we_r) begin
      rdata_r <= bus_rdata;
    end else if (timeout_s && !bus_we_r) begin
      rdata_r <= DW'(DMEM_TIMEOUT_DATA);
    end else begin
      rdata_r <= rdata_r;
    end
  end

  // Misaligned pulse (coincides with DONE) and sticky watchdog error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misaligned_r <= 1'b0;
      bus_error_r  <= 1'b0;
    end else begin
      misaligned_r <= misalign_s;
      bus_error_r  <= bus_error_r | timeout_s;
    end
  end

  assign bus_req    = bus_req_r;
  assign bus_we     = bus_we_r;
  assign bus_addr   = bus_addr_r;
  assign bus_wdata  = bus_wdata_r;
  assign bus_be     = bus_req_r ? DMEM_BE_WORD : 4'h0;
  assign rdata      = rdata_r;
  assign misaligned = misaligned_r;
  assign bus_error  = bus_error_r;

endmodule

// File: tb/tb_rv32_dmem_bridge.sv
// ---------------------------------------------------------------------------
// tb_rv32_dmem_bridge
// Directed bench for rv32_dmem_bridge. The stimulus process plays both the
// core and the bus slave; expected commits and expected bus grants are
// pushed into queues, and two monitors pop and compare them whenever the
// DUT commits an access (stall low in DONE) or a grant is accepted.
// ---------------------------------------------------------------------------
module tb_rv32_dmem_bridge;

  logic        clk;
  logic        reset_n;
  logic [31:0] address;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        misaligned;
  logic        bus_error;

  int checks = 0;
  int errors = 0;
  int grants = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        err;
  } commit_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } busreq_t;

  commit_t commit_q[$];
  busreq_t bus_q[$];

  rv32_dmem_bridge #(
    .AW(32), .DW(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_gnt   (bus_gnt),
    .bus_rvalid(bus_rvalid),
    .bus_rdata (bus_rdata),
    .misaligned(misaligned),
    .bus_error (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Commit monitor: the core commits when it has an access and stall is low.
  always @(negedge clk) begin
    #2;
    if (reset_n && (MemRead || MemWrite) && !stall) begin
      if (commit_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got commit at addr %h expected none", address);
      end else begin
        commit_t e;
        e = commit_q.pop_front();
        chk("commit_rdata", rdata, e.rdata);
        chk("commit_misaligned", {31'd0, misaligned}, {31'd0, e.mis});
        chk("commit_bus_error", {31'd0, bus_error}, {31'd0, e.err});
      end
    end
  end

  // Bus monitor: every accepted grant must match the next expected request.
  always @(negedge clk) begin
    #2;
    if (reset_n && bus_req && bus_gnt) begin
      grants++;
      if (bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got request to %h expected none", bus_addr);
      end else begin
        busreq_t b;
        b = bus_q.pop_front();
        chk("bus_we", {31'd0, bus_we}, {31'd0, b.we});
        chk("bus_addr", bus_addr, b.addr);
        chk("bus_be", {28'd0, bus_be}, 32'h0000_000F);
        if (b.we) chk("bus_wdata", bus_wdata, b.wd);
      end
    end
  end

  // One core access: hold the request until commit while answering the bus.
  // gnt_at = index of the bus_req cycle that gets the grant (0 = never).
  task automatic run_access(input string name, input bit rd, input bit wr,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int gnt_at, input bit same, input logic [31:0] resp,
                            input int exp_stall, input int exp_req, input int exp_mis);
    int  n_stall = 0;
    int  n_req   = 0;
    int  n_mis   = 0;
    bit  rv_pend = 1'b0;
    bit  done    = 1'b0;
    @(posedge clk); #1;
    MemRead  = rd;
    MemWrite = wr;
    address  = a;
    wdata    = wd;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = 32'h0;
      if (stall) n_stall++;
      if (misaligned) n_mis++;
      if (rv_pend) begin
        bus_rvalid = 1'b1;
        bus_rdata  = resp;
        rv_pend    = 1'b0;
      end else if (bus_req) begin
        n_req++;
        if (gnt_at != 0 && n_req == gnt_at) begin
          bus_gnt = 1'b1;
          if (same) begin
            bus_rvalid = 1'b1;
            bus_rdata  = resp;
          end else begin
            rv_pend = 1'b1;
          end
        end
      end
      if (!stall) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_complete: got no DONE within 64 cycles expected DONE", name);
    end
    chk({name, "_stall_cycles"}, n_stall, exp_stall);
    chk({name, "_req_cycles"}, n_req, exp_req);
    chk({name, "_misaligned_pulses"}, n_mis, exp_mis);
  endtask

  task automatic core_idle(input int n);
    @(posedge clk); #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    for (int i = 1; i < n; i++) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    address    = 32'h0;
    wdata      = 32'h0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = 32'h0;

    // Reset state.
    #3;
    chk("reset_bus_req", {31'd0, bus_req}, 32'd0);
    chk("reset_bus_we", {31'd0, bus_we}, 32'd0);
    chk("reset_bus_addr", bus_addr, 32'h0);
    chk("reset_bus_wdata", bus_wdata, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_flags", {29'd0, misaligned, bus_error, stall}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Aligned load, grant first REQ cycle, response next cycle.
    commit_q.push_back('{32'h1234_5678, 1'b0, 1'b0});
    bus_q.push_back('{1'b0, 32'h0000_0100, 32'h0});
    run_access("load", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 1'b0, 32'h1234_5678, 3, 1, 0);
    core_idle(2);

    // Aligned store, grant in the 4th REQ cycle; rdata must not change.
    commit_q.push_back('{32'h1234_5678, 1'b0, 1'b0});
    bus_q.push_back('{1'b1, 32'h0000_0204, 32'hCAFE_F00D});
    run_access("store", 1'b0, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, 4, 1'b0, 32'h0BAD_0BAD, 6, 4, 0);
    core_idle(2);

    // Misaligned load: no bus traffic, rdata forced to zero.
    commit_q.push_back('{32'h0, 1'b1, 1'b0});
    run_access("misaligned", 1'b1, 1'b0, 32'h0000_0102, 32'h0, 1, 1'b0, 32'h0, 1, 0, 1);
    core_idle(2);

    // Back-to-back loads with grant and response in the same cycle.
    commit_q.push_back('{32'hA5A5_0010, 1'b0, 1'b0});
    bus_q.push_back('{1'b0, 32'h0000_0010, 32'h0});
    run_access("b2b_first", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 1'b1, 32'hA5A5_0010, 2, 1, 0);
    commit_q.push_back('{32'h5A5A_0014, 1'b0, 1'b0});
    bus_q.push_back('{1'b0, 32'h0000_0014, 32'h0});
    run_access("b2b_second", 1'b1, 1'b0, 32'h0000_0014, 32'h0, 1, 1'b1, 32'h5A5A_0014, 2, 1, 0);
    core_idle(3);
    chk("b2b_grants", grants, 4);

    // Reset while in WAIT.
    bus_q.push_back('{1'b0, 32'h0000_0300, 32'h0});
    @(posedge clk); #1;
    MemRead = 1'b1;
    address = 32'h0000_0300;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wait_req_seen", {31'd0, bus_req}, 32'd1);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    chk("rst_wait_in_wait", {30'd0, stall, bus_req}, 32'd2);
    reset_n = 1'b0;
    #1;
    chk("rst_wait_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_wait_stall", {31'd0, stall}, 32'd0);
    MemRead = 1'b0;
    @(negedge clk);
    reset_n    = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_rvalid = 1'b0;
    bus_rdata  = 32'h0;
    #2;
    chk("stray_rvalid_rdata", rdata, 32'h0);
    chk("stray_rvalid_idle", {30'd0, stall, bus_req}, 32'd0);

    // Recovery after reset: grant in the 2nd REQ cycle.
    commit_q.push_back('{32'h0BAD_F00D, 1'b0, 1'b0});
    bus_q.push_back('{1'b0, 32'h0000_0020, 32'h0});
    run_access("post_reset_load", 1'b1, 1'b0, 32'h0000_0020, 32'h0, 2, 1'b0, 32'h0BAD_F00D, 4, 2, 0);
    core_idle(2);

`ifdef DMEM_TIMEOUT_EN
    // Grant never comes: watchdog abandons after 8 REQ cycles.
    commit_q.push_back('{32'hDEAD_BEEF, 1'b0, 1'b1});
    run_access("timeout", 1'b1, 1'b0, 32'h0000_0400, 32'h0, 0, 1'b0, 32'h0, 9, 8, 0);
    core_idle(4);
    @(negedge clk); #2;
    chk("timeout_error_sticky", {31'd0, bus_error}, 32'd1);
    chk("timeout_req_dropped", {31'd0, bus_req}, 32'd0);
`else
    @(negedge clk); #2;
    chk("no_watchdog_error", {31'd0, bus_error}, 32'd0);
`endif

    chk("total_grants", grants, 6);
    chk("commit_q_empty", commit_q.size(), 32'd0);
    chk("bus_q_empty", bus_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
